mdu_seq: RTL
============

Name: mdu_seq

Overview:
Iterative multiply/divide unit with architectural HI/LO registers. It is the sequential, parametrised successor to the combinational mult/div path inside the ALU. The CPU issues one operation with a start pulse, the unit stays busy for a fixed number of cycles, and it then updates HI/LO together with a one-cycle done pulse. It sits beside the ALU in the execute stage; the pipeline stalls on busy before any mfhi/mflo.

Parameters:
WIDTH, 32, operand and HI/LO width; any even value ≥ 4.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request; sampled only in IDLE.
op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x reserved.
rs_data  in  WIDTH  multiplicand / dividend / mthi-mtlo source.
rt_data  in  WIDTH  multiplier / divisor.
busy  out  1  high while an operation is in flight.
done  out  1  one-cycle pulse on the edge HI/LO commit.
div_by_zero  out  1  set on div/divu with rt_data==0; held until the next accepted start.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; hi, lo, counter and internal regs = 0; busy=0; done=0; div_by_zero=0. Reset asserted mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE with start=1 and op reserved (11x): no effect; state stays IDLE.
- IDLE with start=1 and op=mthi/mtlo at edge k:
  - hi (or lo) <= rs_data at edge k.
  - done=1 for the cycle after edge k.
  - busy stays 0.
- IDLE with start=1 and op=div/divu with rt_data==0 at edge k:
  - div_by_zero=1; hi/lo unchanged.
  - done=1 after edge k; busy stays 0.
- IDLE with start=1 and op=mult/multu/div/divu (nonzero divisor) at edge k:
  - Latch op and operands. For signed ops, latch magnitudes and record result signs.
  - Clear div_by_zero. busy=1. Enter CALC with counter=WIDTH.
- CALC, one iteration per cycle, counter decrements; leave for FIX when counter reaches 1.
  - mult: shift-add on the unsigned 2*WIDTH product.
  - div: restoring divide producing one quotient bit per cycle.
- FIX (1 cycle): apply signs.
  - Signed product is negated if the operand signs differ.
  - Quotient is negated if the signs differ, giving truncation toward zero.
  - Remainder takes the sign of the dividend.
- DONE edge (k+WIDTH+1):
  - mult/multu: hi = upper WIDTH bits, lo = lower WIDTH bits.
  - div/divu: lo = quotient, hi = remainder.
  - done=1 and busy=0 for the following cycle. Return to IDLE.
- Total latency: WIDTH+1 edges from the accepting edge to commit.
- Signed overflow, -2^(WIDTH-1) / -1: lo = 0x8000_0000 (wraps), hi = 0; no flag.
- start while busy: ignored, with no queuing. Operand changes while busy have no effect.
- start sampled in the same cycle as the done pulse (state IDLE) is accepted normally. Back-to-back issue is therefore one op per WIDTH+2 cycles.
- hi/lo change only on commit, mthi/mtlo, or reset.

Test Plan:
1. mult, rs=0x00000002, rt=0xFFFFFFFD → after 33 edges: hi=0xFFFFFFFF, lo=0xFFFFFFFA; done is a single-cycle pulse; busy high for exactly 33 cycles.
2. multu with the same operands → hi=0x00000001, lo=0xFFFFFFFA. div rs=0x000000F0, rt=0xFFFFFFFE → lo=0xFFFFFF88, hi=0x00000000.
3. div rs=0x000000F8, rt=0xFFFFFFF6 → lo=0xFFFFFFE8, hi=0x00000008.
4. div rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0.
5. divu rs=0x12345678, rt=0 → div_by_zero=1, done one cycle later, hi/lo unchanged. Then mtlo rs=0xA5A5A5A5 → lo=0xA5A5A5A5 and div_by_zero cleared.
6. Mid-op robustness:
   - start mult, re-pulse start with different operands at cycle 10 → ignored; the result matches the first operands.
   - Separately, drop rst_n at cycle 15 of a div → busy=0, hi=lo=0, and no done pulse.
   - Repeat with WIDTH=8: mult 0x7F × 0x80 gives hi=0xC0, lo=0x80 after 9 edges.

Source files
------------

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - issue/result bus between the CPU execute stage and mdu_seq
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative multiply/divide unit with HI/LO registers
module mdu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic  clk,
  input  logic  rst_n,
  mdu_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  // acc:qr is the running product for mult, remainder:dividend/quotient for div
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] qr;
  logic [WIDTH-1:0] opnd;

  logic             signed_op;
  logic             rs_neg;
  logic             rt_neg;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    signed_op = ~bus.op[0];
    rs_neg    = signed_op & bus.rs_data[WIDTH-1];
    rt_neg    = signed_op & bus.rt_data[WIDTH-1];
    rs_mag    = rs_neg ? -bus.rs_data : bus.rs_data;
    rt_mag    = rt_neg ? -bus.rt_data : bus.rt_data;
    add_sum   = {1'b0, acc} + {1'b0, opnd & {WIDTH{qr[0]}}};
    shifted   = {acc, qr[WIDTH-1]};
    ge        = shifted >= {1'b0, opnd};
    // partial remainder minus divisor always fits WIDTH bits when it is kept
    trial     = shifted[WIDTH-1:0] - opnd;
    prod_fix  = neg_q ? -{acc, qr} : {acc, qr};
    quo_fix   = neg_q ? -qr : qr;
    rem_fix   = neg_r ? -acc : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      is_div          <= 1'b0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      acc             <= '0;
      qr              <= '0;
      opnd            <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.hi          <= '0;
      bus.lo          <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        // DONE is the commit-pulse cycle and takes a new start exactly like IDLE
        IDLE, DONE: begin
          state <= IDLE;
          if (bus.start) begin
            case (bus.op)
              OP_MTHI: begin
                bus.hi          <= bus.rs_data;
                bus.done        <= 1'b1;
                bus.div_by_zero <= 1'b0;
              end
              OP_MTLO: begin
                bus.lo          <= bus.rs_data;
                bus.done        <= 1'b1;
                bus.div_by_zero <= 1'b0;
              end
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                if (bus.op[1] && (bus.rt_data == '0)) begin
                  bus.div_by_zero <= 1'b1;
                  bus.done        <= 1'b1;
                end else begin
                  is_div          <= bus.op[1];
                  neg_q           <= rs_neg ^ rt_neg;
                  neg_r           <= rs_neg;
                  acc             <= '0;
                  qr              <= rs_mag;
                  opnd            <= rt_mag;
                  cnt             <= CNT_W'(WIDTH);
                  bus.busy        <= 1'b1;
                  bus.div_by_zero <= 1'b0;
                  state           <= CALC;
                end
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          if (is_div) begin
            acc <= ge ? trial : shifted[WIDTH-1:0];
            qr  <= {qr[WIDTH-2:0], ge};
          end else begin
            acc <= add_sum[WIDTH:1];
            qr  <= {add_sum[0], qr[WIDTH-1:1]};
          end
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            bus.lo <= quo_fix;
            bus.hi <= rem_fix;
          end else begin
            bus.hi <= prod_fix[2*WIDTH-1:WIDTH];
            bus.lo <= prod_fix[WIDTH-1:0];
          end
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
